traffic_fsm: RTL and testbench
==============================

TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 Parameter TBASE, default 6: base green duration, in ticks.
REQ-002 Parameter TEXT, default 3: extension duration and walk duration, in ticks.
REQ-003 Parameter TYEL, default 2: yellow duration, in ticks.
REQ-004 Parameter legality: all parameters 4-bit, range 1..15; 0 is illegal and behaviour is undefined.
REQ-005 clk  in  1  system clock; all state updates occur on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset (driven from synchronizer reset_sync).
REQ-007 sensor_sync  in  1  synchronized side-street vehicle sensor, level.
REQ-008 wr_sync  in  1  synchronized walk request, level.
REQ-009 prog_sync  in  1  synchronized reprogram, level; forces a cycle restart.
REQ-010 tick  in  1  one-cycle timing enable (1 Hz strobe); duration counter advances only when tick=1.
REQ-011 main_lights  out  3  {R,Y,G} for the main street.
REQ-012 side_lights  out  3  {R,Y,G} for the side street.
REQ-013 walk_light  out  1  pedestrian walk lamp.
REQ-014 walk_pending  out  1  latched walk request not yet served.
REQ-015 state_code  out  3  MG1=0, MG2=1, MY=2, WALK=3, SG=4, SY=5.

Function
REQ-016 Every state shall last an exact number of ticks. The counter loads N on state entry, decrements on each tick, and the transition occurs on the tick where the counter equals 1.
REQ-017 MG1 (main 001, side 100) shall last TBASE ticks, then go to MG2.
REQ-018 MG2 (main 001, side 100) shall last TEXT ticks if sensor_sync=1 in the cycle MG2 is entered, otherwise TBASE ticks, then go to MY.
REQ-019 MY (main 010, side 100) shall last TYEL ticks, then go to WALK if walk_pending=1, else to SG.
REQ-020 WALK (main 100, side 100, walk_light=1) shall last TEXT ticks, then go to SG.
REQ-021 walk_pending shall clear on the WALK->SG transition cycle.
REQ-022 SG (main 100, side 001) shall last TBASE ticks. If sensor_sync=1 on the final tick and SG is not yet extended, the counter reloads TEXT, the ext flag sets, and the FSM stays in SG. Otherwise the FSM goes to SY.
REQ-023 SG shall be extended at most once per visit; the ext flag clears on SG exit.
REQ-024 SY (main 100, side 010) shall last TYEL ticks, then go to MG1.
REQ-025 walk_light shall be 1 only in WALK; main and side shall never both be non-red in the same cycle.
REQ-026 walk_pending shall set on any cycle with wr_sync=1, except in WALK, where wr_sync is ignored.
REQ-027 In a cycle where wr_sync=1 coincides with the WALK->SG transition, the clear shall take effect and walk_pending shall read 0 next cycle.
REQ-028 prog_sync=1 shall force MG1 with the counter reloaded to TBASE and the ext flag cleared on the next edge, independent of tick; walk_pending is retained.
REQ-029 All outputs shall be registered; state and light changes appear one clk after the qualifying tick edge.
REQ-030 tick=0 shall freeze the counter and state; prog_sync and reset still act.

Reset
REQ-031 reset=1 shall, at the next rising clk edge, force: state MG1, counter TBASE, ext 0, walk_pending 0, main_lights 001, side_lights 100, walk_light 0, state_code 0.
REQ-032 reset shall have priority over prog_sync, wr_sync and tick in the same cycle.
REQ-033 reset asserted mid-state (any state, any counter value) shall abort that state immediately, with no partial yellow phase.

Verification
REQ-034 Idle cycle: tick=1 every cycle, sensor 0, walk 0 -> state sequence MG1(6) MG2(6) MY(2) SG(6) SY(2), repeating with period 22 cycles.
REQ-035 Sensor held at 1 from reset -> MG2 lasts 3 ticks; SG lasts 9 ticks (6+3); period 22.
REQ-036 wr_sync pulsed 1 cycle during MG1 -> walk_pending=1 next cycle; after MY, WALK lasts 3 ticks with walk_light=1 and main and side both 100; walk_pending=0 on SG entry.
REQ-037 wr_sync held 1 throughout WALK -> no re-latch during WALK; walk_pending set again on the first SG cycle, giving a second WALK in the next cycle.
REQ-038 prog_sync pulsed during SG counter=2 -> next cycle state MG1, main 001, counter 6; a pending walk remains pending.
REQ-039 reset during MY, together with prog_sync and wr_sync -> next cycle all reset values, walk_pending=0; tick held 0 for 10 cycles afterwards -> state stays MG1.

Source files
------------

// File: rtl/traffic_fsm.sv
// ---------------------------------------------------------------------------
// traffic_fsm
//
// Purpose:
//   Main-street / side-street intersection controller with a pedestrian walk
//   phase. Each phase lasts a whole number of timing ticks. The main green is
//   split into a fixed part (MG1) and a sensor-dependent part (MG2). The side
//   green (SG) can be extended once per visit while a vehicle is waiting. A
//   latched walk request inserts an all-red WALK phase between main yellow and
//   side green.
//
// Parameters (4-bit, legal range 1..15; 0 is not supported):
//   TBASE  base green duration, ticks
//   TEXT   green extension and walk duration, ticks
//   TYEL   yellow duration, ticks
//
// Ports:
//   clk           in   system clock, rising-edge active
//   reset         in   synchronous active-high reset
//   sensor_sync   in   side-street vehicle sensor (synchronized level)
//   wr_sync       in   walk request (synchronized level)
//   prog_sync     in   reprogram: restart the cycle at MG1
//   tick          in   one-cycle timing strobe; phase timers advance on it
//   main_lights   out  {R,Y,G} main street, registered
//   side_lights   out  {R,Y,G} side street, registered
//   walk_light    out  pedestrian walk lamp, registered
//   walk_pending  out  walk request latched and not yet served
//   state_code    out  MG1=0 MG2=1 MY=2 WALK=3 SG=4 SY=5, registered
// ---------------------------------------------------------------------------
module traffic_fsm #(
  parameter logic [3:0] TBASE = 4'd6,
  parameter logic [3:0] TEXT  = 4'd3,
  parameter logic [3:0] TYEL  = 4'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_sync,
  input  logic       wr_sync,
  input  logic       prog_sync,
  input  logic       tick,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_light,
  output logic       walk_pending,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG   = 3'd4,
    SY   = 3'd5
  } state_t;

  // Everything visible outside the block, held in one register so that all
  // lamps change on the same edge as the state they belong to.
  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    logic [2:0] code;
  } lamp_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t     state;
  logic [3:0] cnt;        // ticks left in the current phase, 1 = last tick
  logic       ext;        // SG already extended during this visit
  lamp_t      lamp_q;

  logic last_tick;        // qualifying tick that ends the current phase
  logic walk_done;        // WALK -> SG happens on this edge

  // Lamp pattern for a phase. Each output is decoded from the state being
  // entered, so the register update below lands the lamps together with it.
  function automatic lamp_t lamps(input state_t s);
    lamp_t l;
    // NOTE: every field gets a value before the case so no path leaves
    // one unassigned; the same habit is what keeps always_comb latch-free.
    l.main = RED;
    l.side = RED;
    l.walk = 1'b0;
    l.code = s;
    case (s)
      MG1, MG2: l.main = GRN;
      MY:       l.main = YEL;
      WALK:     l.walk = 1'b1;
      SG:       l.side = GRN;
      SY:       l.side = YEL;
      default:  l.main = GRN;
    endcase
    return l;
  endfunction

  assign last_tick = tick && (cnt == 4'd1);
  // Reprogram pre-empts the transition, so a walk cut short stays pending.
  assign walk_done = (state == WALK) && last_tick && !prog_sync;

  // Single sequential process: state, phase timer, extension flag, walk latch
  // and the registered lamp outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples pre-edge values regardless of statement order.
      state        <= MG1;
      cnt          <= TBASE;
      ext          <= 1'b0;
      walk_pending <= 1'b0;
      lamp_q       <= lamps(MG1);
    end else begin
      // Walk latch: serving the walk wins over a simultaneous request, and
      // requests are ignored while the walk is being served.
      if (walk_done) begin
        walk_pending <= 1'b0;
      end else if (wr_sync && (state != WALK)) begin
        walk_pending <= 1'b1;
      end

      if (prog_sync) begin
        state  <= MG1;
        cnt    <= TBASE;
        ext    <= 1'b0;
        lamp_q <= lamps(MG1);
      end else if (tick) begin
        if (!last_tick) begin
          cnt <= cnt - 4'd1;
        end else begin
          case (state)
            MG1: begin
              // Waiting side traffic shortens the second half of main green.
              state  <= MG2;
              cnt    <= sensor_sync ? TEXT : TBASE;
              lamp_q <= lamps(MG2);
            end
            MG2: begin
              state  <= MY;
              cnt    <= TYEL;
              lamp_q <= lamps(MY);
            end
            MY: begin
              if (walk_pending) begin
                state  <= WALK;
                cnt    <= TEXT;
                lamp_q <= lamps(WALK);
              end else begin
                state  <= SG;
                cnt    <= TBASE;
                lamp_q <= lamps(SG);
              end
            end
            WALK: begin
              state  <= SG;
              cnt    <= TBASE;
              lamp_q <= lamps(SG);
            end
            SG: begin
              // One extension per visit; the lamps do not change on it.
              if (sensor_sync && !ext) begin
                cnt <= TEXT;
                ext <= 1'b1;
              end else begin
                state  <= SY;
                cnt    <= TYEL;
                ext    <= 1'b0;
                lamp_q <= lamps(SY);
              end
            end
            SY: begin
              state  <= MG1;
              cnt    <= TBASE;
              lamp_q <= lamps(MG1);
            end
            default: begin
              // Unused encodings recover to the start of the cycle.
              state  <= MG1;
              cnt    <= TBASE;
              ext    <= 1'b0;
              lamp_q <= lamps(MG1);
            end
          endcase
        end
      end
    end
  end

  assign main_lights = lamp_q.main;
  assign side_lights = lamp_q.side;
  assign walk_light  = lamp_q.walk;
  assign state_code  = lamp_q.code;

  // Safety invariants on the registered outputs.
  a_no_conflict : assert property (@(posedge clk) disable iff (reset)
    (main_lights == RED) || (side_lights == RED));

  a_walk_all_red : assert property (@(posedge clk) disable iff (reset)
    walk_light |-> ((main_lights == RED) && (side_lights == RED)));

endmodule

// File: tb/tb_traffic_fsm.sv
// ---------------------------------------------------------------------------
// tb_traffic_fsm
//
// Self-checking bench for traffic_fsm with default parameters
// (TBASE=6, TEXT=3, TYEL=2). Each step drives one cycle of inputs, pushes the
// expected post-edge outputs onto a scoreboard queue, and pops and compares
// them at the following falling edge. Long regular sequences come from a
// vector table with repeat counts; reprogram and reset corner cases are
// written out by hand.
// ---------------------------------------------------------------------------
module tb_traffic_fsm;

  localparam logic [2:0] C_MG1  = 3'd0;
  localparam logic [2:0] C_MG2  = 3'd1;
  localparam logic [2:0] C_MY   = 3'd2;
  localparam logic [2:0] C_WALK = 3'd3;
  localparam logic [2:0] C_SG   = 3'd4;
  localparam logic [2:0] C_SY   = 3'd5;

  typedef struct packed {
    logic [2:0] code;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    logic       pend;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       prog;
    logic       wr;
    logic       sens;
    logic       tk;
    int         reps;
    logic [2:0] code;
    logic       pend;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_sync = 1'b0;
  logic       wr_sync = 1'b0;
  logic       prog_sync = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_light;
  logic       walk_pending;
  logic [2:0] state_code;

  obs_t  exp_q[$];
  vec_t  vecs[$];
  string vec_names[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  traffic_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_sync  (sensor_sync),
    .wr_sync      (wr_sync),
    .prog_sync    (prog_sync),
    .tick         (tick),
    .main_lights  (main_lights),
    .side_lights  (side_lights),
    .walk_light   (walk_light),
    .walk_pending (walk_pending),
    .state_code   (state_code)
  );

  always #5 clk = ~clk;

  // Expected outputs for a phase, from the lamp table of the controller.
  function automatic obs_t expect_for(input logic [2:0] code, input logic pend);
    obs_t o;
    o.code = code;
    o.pend = pend;
    o.walk = 1'b0;
    o.main = 3'b100;
    o.side = 3'b100;
    case (code)
      C_MG1, C_MG2: o.main = 3'b001;
      C_MY:         o.main = 3'b010;
      C_WALK:       o.walk = 1'b1;
      C_SG:         o.side = 3'b001;
      C_SY:         o.side = 3'b010;
      default:      o.main = 3'bxxx;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got code=%0d main=%b side=%b walk=%b pend=%b, expected code=%0d main=%b side=%b walk=%b pend=%b",
               name, got.code, got.main, got.side, got.walk, got.pend,
               exp.code, exp.main, exp.side, exp.walk, exp.pend);
    end
  endtask

  // Drive one cycle of inputs 'reps' times; after each rising edge the
  // outputs must show phase 'code' with walk_pending 'pend'.
  task automatic step(input string name, input logic rst, input logic prog,
                      input logic wr, input logic sens, input logic tk,
                      input int reps, input logic [2:0] code, input logic pend);
    obs_t got;
    obs_t exp;
    for (int r = 0; r < reps; r++) begin
      reset       = rst;
      prog_sync   = prog;
      wr_sync     = wr;
      sensor_sync = sens;
      tick        = tk;
      exp_q.push_back(expect_for(code, pend));
      @(posedge clk);
      @(negedge clk);
      got = {state_code, main_lights, side_lights, walk_light, walk_pending};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s[%0d]: scoreboard empty", name, r);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("%s[%0d]", name, r), got, exp);
      end
    end
  endtask

  task automatic add(input string name, input logic rst, input logic prog,
                     input logic wr, input logic sens, input logic tk,
                     input int reps, input logic [2:0] code, input logic pend);
    vec_t v;
    v.rst  = rst;
    v.prog = prog;
    v.wr   = wr;
    v.sens = sens;
    v.tk   = tk;
    v.reps = reps;
    v.code = code;
    v.pend = pend;
    vecs.push_back(v);
    vec_names.push_back(name);
  endtask

  initial begin
    // Watchdog: the run is a few hundred cycles.
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);

    // Vector table. The reset row's own sample is the first MG1 cycle.
    //   name            rst prog wr sens tk reps code    pend
    // Idle cycle: 6+6+2+6+2 = 22 cycles per period.
    add("reset",          1, 0,  0, 0,  0, 1,  C_MG1,  0);
    add("reset_prio",     1, 1,  1, 1,  1, 1,  C_MG1,  0);
    add("idle_mg1_a",     0, 0,  0, 0,  1, 5,  C_MG1,  0);
    add("idle_mg2_a",     0, 0,  0, 0,  1, 6,  C_MG2,  0);
    add("idle_my_a",      0, 0,  0, 0,  1, 2,  C_MY,   0);
    add("idle_sg_a",      0, 0,  0, 0,  1, 6,  C_SG,   0);
    add("idle_sy_a",      0, 0,  0, 0,  1, 2,  C_SY,   0);
    add("idle_mg1_b",     0, 0,  0, 0,  1, 6,  C_MG1,  0);
    add("idle_mg2_b",     0, 0,  0, 0,  1, 6,  C_MG2,  0);
    add("idle_my_b",      0, 0,  0, 0,  1, 2,  C_MY,   0);
    add("idle_sg_b",      0, 0,  0, 0,  1, 6,  C_SG,   0);
    add("idle_sy_b",      0, 0,  0, 0,  1, 2,  C_SY,   0);
    add("idle_mg1_c",     0, 0,  0, 0,  1, 1,  C_MG1,  0);
    // Sensor held: MG2 shortened to 3, SG extended once to 6+3.
    add("sens_reset",     1, 0,  0, 1,  1, 1,  C_MG1,  0);
    add("sens_mg1_a",     0, 0,  0, 1,  1, 5,  C_MG1,  0);
    add("sens_mg2_a",     0, 0,  0, 1,  1, 3,  C_MG2,  0);
    add("sens_my_a",      0, 0,  0, 1,  1, 2,  C_MY,   0);
    add("sens_sg_a",      0, 0,  0, 1,  1, 9,  C_SG,   0);
    add("sens_sy_a",      0, 0,  0, 1,  1, 2,  C_SY,   0);
    add("sens_mg1_b",     0, 0,  0, 1,  1, 6,  C_MG1,  0);
    add("sens_mg2_b",     0, 0,  0, 1,  1, 3,  C_MG2,  0);
    add("sens_my_b",      0, 0,  0, 1,  1, 1,  C_MY,   0);
    // Walk request pulse, then a request held across WALK.
    add("walk_reset",     1, 0,  0, 0,  1, 1,  C_MG1,  0);
    add("wr_pulse",       0, 0,  1, 0,  1, 1,  C_MG1,  1);
    add("walk_mg1",       0, 0,  0, 0,  1, 4,  C_MG1,  1);
    add("walk_mg2",       0, 0,  0, 0,  1, 6,  C_MG2,  1);
    add("walk_my",        0, 0,  0, 0,  1, 2,  C_MY,   1);
    add("walk_first",     0, 0,  0, 0,  1, 1,  C_WALK, 1);
    add("walk_wr_held",   0, 0,  1, 0,  1, 2,  C_WALK, 1);
    add("walk_exit_clr",  0, 0,  1, 0,  1, 1,  C_SG,   0);
    add("sg_relatch",     0, 0,  1, 0,  1, 1,  C_SG,   1);
    add("sg_rest",        0, 0,  0, 0,  1, 4,  C_SG,   1);
    add("sy_pend",        0, 0,  0, 0,  1, 2,  C_SY,   1);
    add("mg1_pend",       0, 0,  0, 0,  1, 6,  C_MG1,  1);
    add("mg2_pend",       0, 0,  0, 0,  1, 6,  C_MG2,  1);
    add("my_pend",        0, 0,  0, 0,  1, 2,  C_MY,   1);
    add("walk_second",    0, 0,  0, 0,  1, 3,  C_WALK, 1);
    add("sg_served",      0, 0,  0, 0,  1, 6,  C_SG,   0);
    add("sy_served",      0, 0,  0, 0,  1, 2,  C_SY,   0);
    add("mg1_served",     0, 0,  0, 0,  1, 1,  C_MG1,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vec_names[i], vecs[i].rst, vecs[i].prog, vecs[i].wr, vecs[i].sens,
           vecs[i].tk, vecs[i].reps, vecs[i].code, vecs[i].pend);
    end

    // Reprogram during SG with two ticks left and tick low: restart at MG1
    // with a full-length MG1, keeping the walk request.
    step("p_reset",       1, 0, 0, 0, 1, 1, C_MG1, 0);
    step("p_mg1",         0, 0, 0, 0, 1, 5, C_MG1, 0);
    step("p_mg2",         0, 0, 0, 0, 1, 6, C_MG2, 0);
    step("p_my",          0, 0, 0, 0, 1, 2, C_MY,  0);
    step("p_sg1",         0, 0, 0, 0, 1, 1, C_SG,  0);
    step("p_sg_wr",       0, 0, 1, 0, 1, 1, C_SG,  1);
    step("p_sg_to_cnt2",  0, 0, 0, 0, 1, 3, C_SG,  1);
    step("p_prog",        0, 1, 0, 0, 0, 1, C_MG1, 1);
    step("p_mg1_full",    0, 0, 0, 0, 1, 5, C_MG1, 1);
    step("p_mg2_after",   0, 0, 0, 0, 1, 6, C_MG2, 1);
    step("p_my_after",    0, 0, 0, 0, 1, 2, C_MY,  1);
    step("p_walk",        0, 0, 0, 0, 1, 3, C_WALK, 1);
    step("p_sg_served",   0, 0, 0, 0, 1, 1, C_SG,  0);

    // Reset in MY together with reprogram and walk request, then tick low:
    // no yellow remnant, latch cleared, state frozen until ticks resume.
    step("r_reset",       1, 0, 0, 0, 1, 1, C_MG1, 0);
    step("r_wr",          0, 0, 1, 0, 1, 1, C_MG1, 1);
    step("r_mg1",         0, 0, 0, 0, 1, 4, C_MG1, 1);
    step("r_mg2",         0, 0, 0, 0, 1, 6, C_MG2, 1);
    step("r_my",          0, 0, 0, 0, 1, 1, C_MY,  1);
    step("r_reset_all",   1, 1, 1, 0, 1, 1, C_MG1, 0);
    step("r_frozen",      0, 0, 0, 0, 0, 10, C_MG1, 0);
    step("r_tick",        0, 0, 0, 0, 1, 2, C_MG1, 0);
    step("r_wr_frozen",   0, 0, 1, 0, 0, 1, C_MG1, 1);
    step("r_frozen2",     0, 0, 0, 0, 0, 2, C_MG1, 1);
    step("r_tick2",       0, 0, 0, 0, 1, 3, C_MG1, 1);
    step("r_mg2",         0, 0, 0, 0, 1, 1, C_MG2, 1);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
